// File: rtl/salu_pkg.sv
// Shared definitions for the scalar-ALU arbiter: ALU opcode encoding and result flag layout.
package salu_pkg;

  localparam int OP_WIDTH = 4;

  localparam logic [OP_WIDTH-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_WIDTH-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_WIDTH-1:0] OP_SLL  = 4'd2;
  localparam logic [OP_WIDTH-1:0] OP_SLT  = 4'd3;
  localparam logic [OP_WIDTH-1:0] OP_SLTU = 4'd4;
  localparam logic [OP_WIDTH-1:0] OP_XOR  = 4'd5;
  localparam logic [OP_WIDTH-1:0] OP_SRL  = 4'd6;
  localparam logic [OP_WIDTH-1:0] OP_SRA  = 4'd7;
  localparam logic [OP_WIDTH-1:0] OP_OR   = 4'd8;
  localparam logic [OP_WIDTH-1:0] OP_AND  = 4'd9;
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = 4'd10;
  localparam logic [OP_WIDTH-1:0] OP_BNE  = 4'd11;
  localparam logic [OP_WIDTH-1:0] OP_BLT  = 4'd12;
  localparam logic [OP_WIDTH-1:0] OP_BGE  = 4'd13;
  localparam logic [OP_WIDTH-1:0] OP_BLTU = 4'd14;
  localparam logic [OP_WIDTH-1:0] OP_BGEU = 4'd15;

  typedef struct packed {
    logic ovf;
    logic neg;
    logic zero;
  } salu_flags_t;

endpackage

// File: rtl/salu_rsp_fifo.sv
// Small synchronous circular FIFO for tagged ALU responses; flush empties it in one cycle.
module salu_rsp_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  T                           push_data_i,
  input  logic                       pop_i,
  output T                           head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap explicitly so non-power-of-two depths work.
      if (do_push) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  no_overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/salu_arbiter.sv
// Round-robin sharing of one registered scalar ALU among NUM_REQ requesters,
// with credit-based issue into a small tagged response FIFO.
module salu_arbiter
  import salu_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int RSP_DEPTH  = 2,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_rs1_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_rs2_i,
  input  logic [NUM_REQ-1:0][OP_WIDTH-1:0]    req_op_i,
  output logic [DATA_WIDTH-1:0]               alu_rs1_o,
  output logic [DATA_WIDTH-1:0]               alu_rs2_o,
  output logic [OP_WIDTH-1:0]                 alu_op_o,
  input  logic [DATA_WIDTH-1:0]               alu_res_i,
  input  logic                                alu_zero_i,
  input  logic                                alu_neg_i,
  input  logic                                alu_ovf_i,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i,
  output logic [ID_WIDTH-1:0]                 rsp_id_o,
  output logic [DATA_WIDTH-1:0]               rsp_res_o,
  output logic [2:0]                          rsp_flags_o
);

  localparam int CNT_W = $clog2(RSP_DEPTH+1);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] res;
    salu_flags_t           flags;
  } salu_rsp_t;

  logic [ID_WIDTH-1:0] last_q, last_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic                inflight_q, inflight_d;

  logic [ID_WIDTH-1:0] cand;
  logic [ID_WIDTH-1:0] grant_idx;
  logic                grant_any;
  logic                issue_ok;
  logic                rsp_pop;
  logic [CNT_W:0]      credit_used;
  logic [CNT_W:0]      credit_limit;

  salu_rsp_t           push_data;
  salu_rsp_t           fifo_head;
  logic                fifo_valid;
  logic [CNT_W-1:0]    fifo_count;

  assign rsp_pop = fifo_valid && rsp_ready_i;

  // A slot freed by this cycle's pop may be reused by this cycle's grant.
  always_comb begin
    credit_used  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    credit_limit = (CNT_W+1)'(RSP_DEPTH) + {{CNT_W{1'b0}}, rsp_pop};
    issue_ok     = rst_n && !flush_i && (credit_used < credit_limit);
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_WIDTH'((int'(last_q) + i) % NUM_REQ);
      if (issue_ok && !grant_any && req_valid_i[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    alu_rs1_o   = '0;
    alu_rs2_o   = '0;
    alu_op_o    = OP_ADD;
    if (grant_any) begin
      req_ready_o[grant_idx] = 1'b1;
      alu_rs1_o              = req_rs1_i[grant_idx];
      alu_rs2_o              = req_rs2_i[grant_idx];
      alu_op_o               = req_op_i[grant_idx];
    end
  end

  always_comb begin
    inflight_d = grant_any;
    id_d       = grant_any ? grant_idx : id_q;
    last_d     = grant_any ? grant_idx : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= ID_WIDTH'(NUM_REQ-1);
      id_q       <= '0;
      inflight_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      id_q       <= id_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    push_data.id         = id_q;
    push_data.res        = alu_res_i;
    push_data.flags.ovf  = alu_ovf_i;
    push_data.flags.neg  = alu_neg_i;
    push_data.flags.zero = alu_zero_i;
  end

  salu_rsp_fifo #(
    .T     (salu_rsp_t),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .push_i      (inflight_q),
    .push_data_i (push_data),
    .pop_i       (rsp_pop),
    .head_o      (fifo_head),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

  // Response fields read as zero whenever the FIFO is empty.
  assign rsp_valid_o = fifo_valid;
  assign rsp_id_o    = fifo_valid ? fifo_head.id    : '0;
  assign rsp_res_o   = fifo_valid ? fifo_head.res   : '0;
  assign rsp_flags_o = fifo_valid ? fifo_head.flags : '0;

endmodule

// File: tb/tb_salu_arbiter.sv
// Directed bench for salu_arbiter with a behavioural registered ALU standing in for salu.
module tb_salu_arbiter;
  import salu_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             flush_i;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready_o;
  logic [3:0][31:0] req_rs1;
  logic [3:0][31:0] req_rs2;
  logic [3:0][3:0]  req_op;
  logic [31:0]      alu_rs1_o;
  logic [31:0]      alu_rs2_o;
  logic [3:0]       alu_op_o;
  logic [31:0]      alu_res;
  logic             alu_zero;
  logic             alu_neg;
  logic             alu_ovf;
  logic             rsp_valid_o;
  logic             rsp_ready;
  logic [1:0]       rsp_id_o;
  logic [31:0]      rsp_res_o;
  logic [2:0]       rsp_flags_o;

  int num_compared;
  int num_mismatched;

  salu_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (32),
    .RSP_DEPTH  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_rs1_i   (req_rs1),
    .req_rs2_i   (req_rs2),
    .req_op_i    (req_op),
    .alu_rs1_o   (alu_rs1_o),
    .alu_rs2_o   (alu_rs2_o),
    .alu_op_o    (alu_op_o),
    .alu_res_i   (alu_res),
    .alu_zero_i  (alu_zero),
    .alu_neg_i   (alu_neg),
    .alu_ovf_i   (alu_ovf),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id_o),
    .rsp_res_o   (rsp_res_o),
    .rsp_flags_o (rsp_flags_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural salu: returns {ovf, neg, zero, result}.
  function automatic logic [34:0] saluModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        ovf;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      default: r = a + b;
    endcase
    return {ovf, r[31], (r == 32'd0), r};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {alu_ovf, alu_neg, alu_zero, alu_res} <= '0;
    end else begin
      {alu_ovf, alu_neg, alu_zero, alu_res} <= saluModel(alu_op_o, alu_rs1_o, alu_rs2_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    req_valid[idx] = v;
    req_op[idx]    = op;
    req_rs1[idx]   = a;
    req_rs2[idx]   = b;
  endtask

  task automatic clearRequests();
    req_valid = '0;
    req_op    = '0;
    req_rs1   = '0;
    req_rs2   = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    num_compared++;
    assert (observed === expected) else begin
      num_mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    rst_n     = 1'b0;
    flush_i   = 1'b0;
    rsp_ready = 1'b1;
    clearRequests();

    // Reset: requests present but nothing granted, all outputs quiet.
    for (int r = 0; r < 4; r++) applyStimulus(r, 1'b1, OP_ADD, 32'd9, 32'd9);
    #2;
    checkOutput("rst_req_ready", 64'(req_ready_o), 64'h0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
    checkOutput("rst_rsp_id",    64'(rsp_id_o),    64'h0);
    checkOutput("rst_rsp_res",   64'(rsp_res_o),   64'h0);
    checkOutput("rst_rsp_flags", 64'(rsp_flags_o), 64'h0);
    checkOutput("rst_alu_rs1",   64'(alu_rs1_o),   64'h0);
    checkOutput("rst_alu_op",    64'(alu_op_o),    64'h0);
    clearRequests();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] single op");
    applyStimulus(0, 1'b1, OP_ADD, 32'd5, 32'd7);
    #1;
    checkOutput("single_ready", 64'(req_ready_o), 64'b0001);
    checkOutput("single_rs1",   64'(alu_rs1_o),   64'd5);
    checkOutput("single_rs2",   64'(alu_rs2_o),   64'd7);
    checkOutput("single_op",    64'(alu_op_o),    64'(OP_ADD));
    tick();
    clearRequests();
    checkOutput("single_t1_valid", 64'(rsp_valid_o), 64'h0);
    tick();
    checkOutput("single_t2_valid", 64'(rsp_valid_o), 64'h1);
    checkOutput("single_id",       64'(rsp_id_o),    64'h0);
    checkOutput("single_res",      64'(rsp_res_o),   64'd12);
    checkOutput("single_flags",    64'(rsp_flags_o), 64'b000);
    tick();
    checkOutput("single_popped", 64'(rsp_valid_o), 64'h0);

    $display("[TB] signed overflow");
    applyStimulus(1, 1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1);
    #1;
    checkOutput("ovf_ready", 64'(req_ready_o), 64'b0010);
    tick();
    clearRequests();
    tick();
    checkOutput("ovf_valid", 64'(rsp_valid_o), 64'h1);
    checkOutput("ovf_id",    64'(rsp_id_o),    64'h1);
    checkOutput("ovf_res",   64'(rsp_res_o),   64'h8000_0000);
    checkOutput("ovf_flags", 64'(rsp_flags_o), 64'b110);
    tick();

    // last grant was requester 1, so the rotation starts at 2.
    $display("[TB] round robin");
    for (int r = 0; r < 4; r++) applyStimulus(r, 1'b1, OP_ADD, 32'(100 + r), 32'(r));
    for (int k = 0; k < 10; k++) begin
      if (k == 8) clearRequests();
      #1;
      if (k < 8) checkOutput("rr_grant", 64'(req_ready_o), 64'(4'b0001 << ((2 + k) % 4)));
      else       checkOutput("rr_idle",  64'(req_ready_o), 64'h0);
      if (k >= 2) begin
        checkOutput("rr_rsp_valid", 64'(rsp_valid_o), 64'h1);
        checkOutput("rr_rsp_id",    64'(rsp_id_o),    64'(k % 4));
        checkOutput("rr_rsp_res",   64'(rsp_res_o),   64'(100 + 2 * (k % 4)));
      end
      tick();
    end
    checkOutput("rr_drained", 64'(rsp_valid_o), 64'h0);

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    applyStimulus(2, 1'b1, OP_ADD, 32'd20, 32'd3);
    #1;
    checkOutput("bp_grant0", 64'(req_ready_o), 64'b0100);
    tick();
    applyStimulus(2, 1'b1, OP_ADD, 32'd30, 32'd3);
    #1;
    checkOutput("bp_grant1", 64'(req_ready_o), 64'b0100);
    tick();
    #1;
    checkOutput("bp_block0",    64'(req_ready_o), 64'h0);
    checkOutput("bp_alu_idle",  64'(alu_rs1_o),   64'h0);
    tick();
    checkOutput("bp_block1",    64'(req_ready_o), 64'h0);
    checkOutput("bp_full_valid", 64'(rsp_valid_o), 64'h1);
    checkOutput("bp_full_id",    64'(rsp_id_o),    64'h2);
    checkOutput("bp_full_res",   64'(rsp_res_o),   64'd23);
    // FIFO full: pop and a fresh grant land in the same cycle.
    rsp_ready = 1'b1;
    applyStimulus(2, 1'b1, OP_ADD, 32'd40, 32'd3);
    #1;
    checkOutput("bp_pop_grant", 64'(req_ready_o), 64'b0100);
    checkOutput("bp_pop_res",   64'(rsp_res_o),   64'd23);
    tick();
    clearRequests();
    #1;
    checkOutput("bp_drain1_valid", 64'(rsp_valid_o), 64'h1);
    checkOutput("bp_drain1_res",   64'(rsp_res_o),   64'd33);
    checkOutput("bp_drain1_ready", 64'(req_ready_o), 64'h0);
    tick();
    checkOutput("bp_drain2_valid", 64'(rsp_valid_o), 64'h1);
    checkOutput("bp_drain2_id",    64'(rsp_id_o),    64'h2);
    checkOutput("bp_drain2_res",   64'(rsp_res_o),   64'd43);
    tick();
    checkOutput("bp_empty", 64'(rsp_valid_o), 64'h0);

    $display("[TB] flush");
    applyStimulus(1, 1'b1, OP_ADD, 32'd1, 32'd1);
    #1;
    checkOutput("fl_grant", 64'(req_ready_o), 64'b0010);
    tick();
    clearRequests();
    flush_i = 1'b1;
    applyStimulus(0, 1'b1, OP_ADD, 32'd2, 32'd2);
    #1;
    checkOutput("fl_block", 64'(req_ready_o), 64'h0);
    tick();
    flush_i = 1'b0;
    clearRequests();
    checkOutput("fl_no_rsp0", 64'(rsp_valid_o), 64'h0);
    tick();
    checkOutput("fl_no_rsp1", 64'(rsp_valid_o), 64'h0);

    // Pointer survives flush (last=1), so requester 2 wins over 0.
    $display("[TB] async reset with buffered responses");
    rsp_ready = 1'b0;
    applyStimulus(0, 1'b1, OP_ADD, 32'd7, 32'd0);
    applyStimulus(2, 1'b1, OP_ADD, 32'd8, 32'd0);
    #1;
    checkOutput("fl_last_kept", 64'(req_ready_o), 64'b0100);
    tick();
    #1;
    checkOutput("rst_second_grant", 64'(req_ready_o), 64'b0001);
    tick();
    tick();
    checkOutput("rst_buf_valid", 64'(rsp_valid_o), 64'h1);
    checkOutput("rst_buf_id",    64'(rsp_id_o),    64'h2);
    checkOutput("rst_buf_res",   64'(rsp_res_o),   64'd8);
    checkOutput("rst_buf_ready", 64'(req_ready_o), 64'h0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 64'(rsp_valid_o), 64'h0);
    checkOutput("rst_async_res",   64'(rsp_res_o),   64'h0);
    checkOutput("rst_async_ready", 64'(req_ready_o), 64'h0);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_first_grant", 64'(req_ready_o), 64'b0001);
    checkOutput("rst_post_valid",  64'(rsp_valid_o), 64'h0);
    tick();
    clearRequests();
    rsp_ready = 1'b1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
